parse_stream: RTL and testbench
===============================

Name: parse_stream

Overview:
- Parametrised, flow-controlled successor to the Kyber Parse (uniform rejection sampling) block.
- Consumes a byte stream from the SHAKE/XOF squeeze path, IN_BYTES per beat, through a valid/ready handshake.
- Carries 0–2 leftover bytes across beats, splits each 3-byte group into two 12-bit candidates, and keeps those below Q.
- Buffers accepted coefficients and emits OUT_LANES per beat through a valid/ready handshake until exactly N coefficients have been produced.

Parameters:
- IN_BYTES, 8, bytes per input beat; must be >= 3.
- OUT_LANES, 4, coefficients per output beat; must divide N.
- Q, 3329, rejection bound; a candidate d is accepted iff d < Q.
- N, 256, coefficients per polynomial.
- BUF_DEPTH, 16, coefficient buffer entries; must be >= OUT_LANES + CMAX.
- CMAX is derived, not a parameter: CMAX = 2*floor((IN_BYTES+2)/3).

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; begins a new polynomial and aborts any current one.
- i_ibytes  in  IN_BYTES*8  input bytes; byte 0 at MSBs [IN_BYTES*8-1 -: 8].
- i_ibytes_valid  in  1  input beat valid.
- o_ibytes_ready  out  1  block accepts an input beat.
- o_coeffs  out  OUT_LANES*12  output coefficients; lane 0 at MSBs.
- o_coeffs_valid  out  1  o_coeffs valid.
- i_coeffs_ready  in  1  downstream accepts o_coeffs.
- o_busy  out  1  polynomial in progress.
- o_done  out  1  one-cycle pulse after the final output beat.

Behaviour:
- Reset values: o_ibytes_ready=0, o_coeffs=0, o_coeffs_valid=0, o_busy=0, o_done=0; buffer, residue and counters cleared.
- Reset mid-operation discards everything.
- State machine:
  - IDLE -> RUN on i_start.
  - RUN -> DRAIN when the accepted count reaches N.
  - DRAIN -> IDLE when the final output beat handshakes; o_done pulses in the cycle after that handshake, and o_busy falls in the same cycle.
- i_start in RUN or DRAIN: clear buffer, residue and counters; next cycle is RUN.
- An input beat transfers on i_ibytes_valid && o_ibytes_ready.
- o_ibytes_ready = (state==RUN) && (free buffer entries >= CMAX). It is registered-state driven and has no combinational path from i_ibytes_valid.
- Per accepted beat:
  - Stream = residue bytes (oldest first), then bytes 0..IN_BYTES-1.
  - T = floor(len/3) triplets are formed; the remaining len mod 3 bytes become the new residue.
  - For triplet (b0,b1,b2): d1 = b0 + 256*(b1 mod 16); d2 = floor(b1/16) + 16*b2. Order is d1 then d2.
  - Accepted candidates are appended in stream order.
  - If count + accepted > N, only the first N-count are kept and the rest are dropped.
- Latency: coefficients from a beat handshaked at edge k are eligible for output after edge k (1 cycle).
- o_coeffs_valid = (buffer count >= OUT_LANES).
- o_coeffs presents the oldest OUT_LANES entries and holds stable while o_coeffs_valid && !i_coeffs_ready.
- Push and pop may occur in the same cycle; count' = count + pushed - popped.
- Buffer overflow is impossible by the o_ibytes_ready rule; a design assertion checks count <= BUF_DEPTH.
- Input beats arriving after count reaches N are not accepted, since ready is low. Residue bytes are discarded at the RUN->DRAIN transition.

Test Plan:
1. All-zero bytes, default params:
   - beats 1/2/3 yield 4/6/6 coefficients (residue 2/1/0);
   - 48 beats give 256 zeros in 64 output beats;
   - o_done pulses once, then o_busy=0.
2. All 0xFF bytes for 20 beats:
   - every candidate is 4095 and rejected;
   - o_coeffs_valid stays 0, o_ibytes_ready stays 1, no o_done.
3. Bound check: first bytes 0x00,0x1D,0xD0 give d1=3328 (accepted) and d2=3329 (rejected). Exactly one coefficient, 0xD00, appears from that triplet.
4. Backpressure, i_coeffs_ready=0 throughout:
   - buffer fills and o_ibytes_ready drops when free < 6;
   - o_coeffs holds stable;
   - on release, the sequence matches the golden 768-byte vectors (80 vectors, ../vec/parse) with no loss or duplication.
5. Over-supply: stream a full 768-byte golden vector with random valid/ready gaps. Output equals o_coeffs.vec exactly, and o_ibytes_ready is 0 from the cycle count hits 256.
6. Abort and reset:
   - i_start asserted after 100 coefficients, then a fresh vector: output equals the golden vector from coefficient 0.
   - i_rstn low mid-RUN: all outputs reach reset values immediately, asynchronously.

Source files
------------

// File: rtl/parse_stream.sv
// parse_stream: flow-controlled Kyber Parse (uniform rejection sampling).
// Takes IN_BYTES XOF bytes per beat and carries 0-2 leftover bytes between
// beats. Each 3-byte group becomes two 12-bit candidates, and a candidate is
// kept when it is below Q. Kept coefficients sit in a small buffer and leave
// OUT_LANES at a time until exactly N coefficients have been produced.
module parse_stream #(
  parameter int IN_BYTES  = 8,
  parameter int OUT_LANES = 4,
  parameter int Q         = 3329,
  parameter int N         = 256,
  parameter int BUF_DEPTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic [IN_BYTES*8-1:0]   i_ibytes,
  input  logic                    i_ibytes_valid,
  output logic                    o_ibytes_ready,
  output logic [OUT_LANES*12-1:0] o_coeffs,
  output logic                    o_coeffs_valid,
  input  logic                    i_coeffs_ready,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int TMAX = (IN_BYTES + 2) / 3;   // max triplets per beat
  localparam int CMAX = 2 * TMAX;             // max candidates per beat
  localparam int SLEN = IN_BYTES + 2;         // residue + beat bytes
  localparam int CW   = $clog2(BUF_DEPTH + 1);
  localparam int AW   = $clog2(N + 1);
  localparam int KW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [12:0]   QV      = 13'(Q);
  localparam logic [CW-1:0] RDY_MAX = CW'(BUF_DEPTH - CMAX);
  localparam logic [CW-1:0] LANES_C = CW'(OUT_LANES);
  localparam logic [AW-1:0] N_C     = AW'(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [11:0]   buf_q [BUF_DEPTH];
  logic [11:0]   buf_d [BUF_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [7:0]    res_q [2];
  logic [7:0]    res_d [2];
  logic [1:0]    rcnt_q, rcnt_d;
  logic          done_q, done_d;

  logic [SLEN*8-1:0] strm_v;
  logic [7:0]        strm [SLEN];
  logic [11:0]       cand [CMAX];
  logic              ok   [CMAX];
  logic [11:0]       comp [CMAX];
  logic [7:0]        nres0, nres1;
  int unsigned       trip, rem, kept, limit, base;
  logic              in_fire, pop;

  assign o_ibytes_ready = (state_q == S_RUN) && (cnt_q <= RDY_MAX);
  assign o_coeffs_valid = (cnt_q >= LANES_C);
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = done_q;
  assign in_fire        = i_ibytes_valid && o_ibytes_ready;
  assign pop            = o_coeffs_valid && i_coeffs_ready;

  // Lane 0 (MSBs) is the oldest buffered coefficient.
  always_comb begin
    o_coeffs = '0;
    for (int unsigned l = 0; l < OUT_LANES; l++) begin
      o_coeffs[(OUT_LANES-1-l)*12 +: 12] = buf_q[l];
    end
  end

  // Join residue with the beat, then split it into triplets, candidates and the new residue.
  always_comb begin
    case (rcnt_q)
      2'd0:    strm_v = {i_ibytes, 16'h0000};
      2'd1:    strm_v = {res_q[0], i_ibytes, 8'h00};
      default: strm_v = {res_q[0], res_q[1], i_ibytes};
    endcase
    for (int unsigned i = 0; i < SLEN; i++) begin
      strm[i] = strm_v[(SLEN-1-i)*8 +: 8];
    end
    trip  = ({30'd0, rcnt_q} + IN_BYTES) / 3;
    rem   = ({30'd0, rcnt_q} + IN_BYTES) % 3;
    nres0 = '0;
    nres1 = '0;
    for (int unsigned i = 0; i < SLEN; i++) begin
      if (i == 3 * trip)     nres0 = strm[i];
      if (i == 3 * trip + 1) nres1 = strm[i];
    end
    for (int unsigned t = 0; t < TMAX; t++) begin
      cand[2*t]   = {strm[3*t+1][3:0], strm[3*t]};
      cand[2*t+1] = {strm[3*t+2], strm[3*t+1][7:4]};
      ok[2*t]     = (t < trip) && ({1'b0, cand[2*t]} < QV);
      ok[2*t+1]   = (t < trip) && ({1'b0, cand[2*t+1]} < QV);
    end
  end

  // Next-state: FSM, buffer pop/push, residue and counters.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    rcnt_d  = rcnt_q;
    done_d  = 1'b0;
    base    = {{(32-CW){1'b0}}, cnt_q};
    limit   = 32'(N) - {{(32-AW){1'b0}}, acc_q};
    kept    = 0;
    for (int unsigned c = 0; c < CMAX; c++) comp[c] = '0;

    // The buffer is a shift register with the oldest entry at index 0.
    // A pop shifts by OUT_LANES first, so pushes in the same cycle land
    // right after the surviving entries.
    if (pop) begin
      for (int unsigned i = 0; i < BUF_DEPTH - OUT_LANES; i++) begin
        buf_d[i] = buf_q[i + OUT_LANES];
      end
      for (int unsigned i = BUF_DEPTH - OUT_LANES; i < BUF_DEPTH; i++) begin
        buf_d[i] = '0;
      end
      base = base - OUT_LANES;
    end

    if (in_fire) begin
      for (int unsigned c = 0; c < CMAX; c++) begin
        if (ok[c] && kept < limit) begin
          comp[KW'(kept)] = cand[c];
          kept = kept + 1;
        end
      end
      for (int unsigned p = 0; p < BUF_DEPTH; p++) begin
        if (p >= base && p < base + kept) buf_d[p] = comp[KW'(p - base)];
      end
      res_d[0] = nres0;
      res_d[1] = nres1;
      rcnt_d   = 2'(rem);
    end

    cnt_d = CW'(base + kept);
    acc_d = acc_q + AW'(kept);

    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (acc_d == N_C) begin
          state_d  = S_DRAIN;
          rcnt_d   = '0;
          res_d[0] = '0;
          res_d[1] = '0;
        end
      end
      S_DRAIN: begin
        if (pop && cnt_q == LANES_C) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (i_start) begin
      state_d  = S_RUN;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) buf_d[i] = '0;
      cnt_d    = '0;
      acc_d    = '0;
      rcnt_d   = '0;
      res_d[0] = '0;
      res_d[1] = '0;
      done_d   = 1'b0;
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= S_IDLE;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      res_q[0] <= '0;
      res_q[1] <= '0;
      rcnt_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      rcnt_q   <= rcnt_d;
      done_q   <= done_d;
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
                                  cnt_q <= CW'(BUF_DEPTH));

endmodule

// File: tb/tb_parse_stream.sv
// Scoreboard bench for parse_stream: stimulus pushes expected coefficients,
// a monitor pops and compares on every output handshake.
module tb_parse_stream;
  localparam int IN_BYTES  = 8;
  localparam int OUT_LANES = 4;
  localparam int Q         = 3329;
  localparam int N         = 256;
  localparam int BUF_DEPTH = 16;
  localparam int VBYTES    = 768;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [63:0] ibytes = '0;
  logic        ivalid = 1'b0;
  logic        ready;
  logic [47:0] coeffs;
  logic        cvalid;
  logic        cready = 1'b0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  parse_stream #(
    .IN_BYTES (IN_BYTES),
    .OUT_LANES(OUT_LANES),
    .Q        (Q),
    .N        (N),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_start       (start),
    .i_ibytes      (ibytes),
    .i_ibytes_valid(ivalid),
    .o_ibytes_ready(ready),
    .o_coeffs      (coeffs),
    .o_coeffs_valid(cvalid),
    .i_coeffs_ready(cready),
    .o_busy        (busy),
    .o_done        (done)
  );

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic [11:0] expq [$];
  logic [11:0] gold [$];
  logic [7:0]  vec [VBYTES];
  logic [47:0] mon_exp;
  bit          rnd_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every output handshake against the scoreboard queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (done) begin
        done_cnt++;
        check("done_busy_low", busy, 0);
      end
      if (cvalid && cready) begin
        if (expq.size() < OUT_LANES) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected no output", coeffs);
        end else begin
          mon_exp = '0;
          for (int l = 0; l < OUT_LANES; l++) mon_exp = {mon_exp[35:0], expq.pop_front()};
          check("coeff_beat", coeffs, mon_exp);
        end
      end
    end
  end

  // Random output backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) cready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic send_beat(input logic [63:0] b);
    int t;
    ibytes = b;
    ivalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got ready=0 expected ready=1");
    end else begin
      @(posedge clk);
    end
    #1;
    ivalid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (expq.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_of(input int k);
    logic [63:0] b;
    b = '0;
    for (int j = 0; j < 8; j++) b[63-8*j -: 8] = vec[8*k+j];
    return b;
  endfunction

  // Reference: parse the flat byte stream, independent of beat boundaries.
  task automatic model(input int nbytes);
    logic [11:0] d1, d2;
    gold.delete();
    for (int i = 0; i + 2 < nbytes; i += 3) begin
      d1 = {vec[i+1][3:0], vec[i]};
      d2 = {vec[i+2], vec[i+1][7:4]};
      if (int'(d1) < Q && gold.size() < N) gold.push_back(d1);
      if (int'(d2) < Q && gold.size() < N) gold.push_back(d2);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < VBYTES; i++) vec[i] = 8'($urandom_range(0, 255));
  endtask

  // Fewest beats whose bytes supply N coefficients; leaves gold full.
  task automatic find_kneed(output int kn);
    kn = -1;
    for (int k = 1; k <= VBYTES / 8 && kn < 0; k++) begin
      model(8 * k);
      if (gold.size() == N) kn = k;
    end
    if (kn < 0) begin
      checks++;
      errors++;
      $display("FAIL model_supply: got %0d coeffs expected %0d", gold.size(), N);
      kn = VBYTES / 8;
    end
  endtask

  initial begin
    int kn, k, dc, k100, keep;
    logic [47:0] snap;

    // Reset state
    #23;
    check("rst_ready", ready, 0);
    check("rst_coeffs", coeffs, 0);
    check("rst_cvalid", cvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // T1: all-zero bytes
    cready = 1'b0;
    for (int i = 0; i < N; i++) expq.push_back(12'h000);
    pulse_start();
    check("t1_busy", busy, 1);
    send_beat('0);
    check("t1_b1_cvalid", cvalid, 1);
    check("t1_b1_ready", ready, 1);
    send_beat('0);
    check("t1_b2_ready", ready, 1);
    send_beat('0);
    check("t1_b3_ready", ready, 0);
    cready = 1'b1;
    for (int i = 3; i < 48; i++) send_beat('0);
    check("t1_ready_at_N", ready, 0);
    wait_drain(2000);
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_count", done_cnt, 1);
    check("t1_busy_end", busy, 0);
    check("t1_cvalid_end", cvalid, 0);

    // T2: all-0xFF bytes, everything rejected
    dc = done_cnt;
    pulse_start();
    for (int i = 0; i < 20; i++) send_beat(64'hFFFF_FFFF_FFFF_FFFF);
    check("t2_ready", ready, 1);
    check("t2_cvalid", cvalid, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t2_no_done", done_cnt, dc);
    check("t2_busy", busy, 1);

    // T3: bound check, 3328 kept and 3329 dropped
    pulse_start();
    expq.push_back(12'd3328); expq.push_back(12'd513);
    expq.push_back(12'd48);   expq.push_back(12'd1284);
    expq.push_back(12'd96);   expq.push_back(12'd2055);
    expq.push_back(12'd144);  expq.push_back(12'd2826);
    send_beat(64'h001D_D001_0203_0405);
    send_beat(64'h0607_0809_0A0B_0C0D);
    wait_drain(200);
    check("t3_leftover_cvalid", cvalid, 0);

    // T4: backpressure then release
    fill_random();
    find_kneed(kn);
    dc = done_cnt;
    cready = 1'b0;
    pulse_start();
    foreach (gold[i]) expq.push_back(gold[i]);
    k = 0;
    do begin
      send_beat(beat_of(k));
      k++;
    end while (ready && k < kn);
    check("t4_ready_dropped", ready, 0);
    check("t4_cvalid", cvalid, 1);
    snap = coeffs;
    repeat (4) begin
      @(negedge clk);
      check("t4_hold", coeffs, snap);
    end
    @(posedge clk);
    #1;
    cready = 1'b1;
    while (k < kn) begin
      send_beat(beat_of(k));
      k++;
    end
    check("t4_ready_at_N", ready, 0);
    wait_drain(3000);
    repeat (3) @(posedge clk);
    #1;
    check("t4_done", done_cnt, dc + 1);

    // T5: random input gaps and output backpressure, then over-supply
    fill_random();
    find_kneed(kn);
    dc = done_cnt;
    pulse_start();
    foreach (gold[i]) expq.push_back(gold[i]);
    rnd_ready = 1'b1;
    for (int b = 0; b < kn; b++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_beat(beat_of(b));
    end
    check("t5_ready_at_N", ready, 0);
    ibytes = beat_of(kn);
    ivalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t5_oversupply_ready", ready, 0);
    end
    ivalid = 1'b0;
    wait_drain(4000);
    rnd_ready = 1'b0;
    #2;
    cready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_done", done_cnt, dc + 1);

    // T6: abort after 100+ coefficients, then a fresh vector from zero
    fill_random();
    k100 = 0;
    for (int b = 1; b <= VBYTES / 8 && k100 == 0; b++) begin
      model(8 * b);
      if (gold.size() >= 100) k100 = b;
    end
    keep = (gold.size() / OUT_LANES) * OUT_LANES;
    pulse_start();
    for (int i = 0; i < keep; i++) expq.push_back(gold[i]);
    for (int b = 0; b < k100; b++) send_beat(beat_of(b));
    wait_drain(1000);
    dc = done_cnt;
    pulse_start();
    fill_random();
    find_kneed(kn);
    foreach (gold[i]) expq.push_back(gold[i]);
    for (int b = 0; b < kn; b++) send_beat(beat_of(b));
    wait_drain(3000);
    repeat (3) @(posedge clk);
    #1;
    check("t6_done", done_cnt, dc + 1);

    // Asynchronous reset mid-RUN
    fill_random();
    cready = 1'b0;
    pulse_start();
    send_beat(beat_of(0));
    send_beat(beat_of(1));
    #2;
    rstn = 1'b0;
    #1;
    check("arst_ready", ready, 0);
    check("arst_coeffs", coeffs, 0);
    check("arst_cvalid", cvalid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    expq.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("arst_idle_busy", busy, 0);
    check("arst_idle_ready", ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
